// File: rtl/btn_pulse_frontend.sv
// Turns raw push-buttons into clean one-cycle command pulses, with optional hold-to-repeat.
// Pulse and held appear DEBOUNCE_CYCLES+2 edges after the raw level change.
module btn_pulse_frontend #(
  parameter int                 NUM_BTN         = 4,
  parameter int                 DEBOUNCE_CYCLES = 16,
  parameter int                 REPEAT_DELAY    = 64,
  parameter int                 REPEAT_RATE     = 16,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b0010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] pulse,
  output logic [NUM_BTN-1:0] held,
  output logic               any_pulse
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_PRESSED,
    ST_REPEAT,
    ST_DEB_RELEASE
  } state_t;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] w_fire_q;
  logic [NUM_BTN-1:0] w_held_st;
  logic [NUM_BTN-1:0] r_pulse;
  logic [NUM_BTN-1:0] r_held;
  logic               r_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_fire;
    logic          r_fire;
    logic          w_s;

    assign w_s = r_sync2[i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_fire  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_fire  <= w_fire;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fire      = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            w_state_nxt = ST_DEB_PRESS;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        ST_DEB_PRESS: begin
          if (!w_s) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
            w_fire      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!w_s) begin
            w_state_nxt = ST_DEB_RELEASE;
            w_cnt_nxt   = CNT_ONE;
          end else if (REPEAT_MASK[i] && (r_cnt == RD_LAST)) begin
            w_state_nxt = ST_REPEAT;
            w_cnt_nxt   = '0;
            w_fire      = 1'b1;
          end else if (r_cnt != CNT_MAX) begin
            // Saturating so a long non-repeating hold never wraps.
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!w_s) begin
            w_state_nxt = ST_DEB_RELEASE;
            w_cnt_nxt   = CNT_ONE;
          end else if (r_cnt == RR_LAST) begin
            w_cnt_nxt = '0;
            w_fire    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_DEB_RELEASE: begin
          // A bounce back to pressed resumes the hold and restarts the repeat delay.
          if (w_s) begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_fire_q[i]  = r_fire;
    assign w_held_st[i] = (r_state == ST_PRESSED) || (r_state == ST_REPEAT) ||
                          (r_state == ST_DEB_RELEASE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse <= '0;
      r_held  <= '0;
      r_any   <= 1'b0;
    end else begin
      r_pulse <= w_fire_q;
      r_held  <= w_held_st;
      r_any   <= |w_fire_q;
    end
  end

  assign pulse     = r_pulse;
  assign held      = r_held;
  assign any_pulse = r_any;

endmodule

// File: tb/tb_btn_pulse_frontend.sv
// Directed bench for btn_pulse_frontend: edge e is the e-th rising edge of a stimulus segment.
module tb_btn_pulse_frontend;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] pulse;
  logic [3:0] held;
  logic       any_pulse;

  always #5 clk = ~clk;

  btn_pulse_frontend dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .pulse    (pulse),
    .held     (held),
    .any_pulse(any_pulse)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         b2b_err = 0;
  int         or_err = 0;
  int         rst_err = 0;
  logic [3:0] prev_pl = 4'h0;
  logic [3:0] pl [0:511];
  logic [3:0] hd [0:511];
  logic       ap [0:511];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; leaves at a falling edge.
  task automatic run(input int first, input int n, input logic [3:0] raw);
    for (int e = first; e < first + n; e++) begin
      btn_raw = raw;
      @(posedge clk);
      #1;
      pl[e] = pulse;
      hd[e] = held;
      ap[e] = any_pulse;
      if ((pulse & prev_pl) != 4'h0) b2b_err++;
      if (any_pulse !== (|pulse)) or_err++;
      prev_pl = pulse;
      @(negedge clk);
    end
  endtask

  function automatic int npulse(input int ch, input int a, input int b);
    int c = 0;
    for (int e = a; e <= b; e++) if (pl[e][ch]) c++;
    return c;
  endfunction

  function automatic int nheld(input int ch, input int a, input int b, input logic lvl);
    int c = 0;
    for (int e = a; e <= b; e++) if (hd[e][ch] == lvl) c++;
    return c;
  endfunction

  initial begin
    // All buttons pressed through reset, then released.
    reset   = 1'b1;
    btn_raw = 4'hF;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if ((pulse | held) != 4'h0 || any_pulse) rst_err++;
    end
    check("reset_quiet", rst_err, 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 26, 4'hF);
    check("all_pulse_e17", pl[17], 4'h0);
    check("all_pulse_e18", pl[18], 4'hF);
    check("all_pulse_e19", pl[19], 4'h0);
    check("all_held_e17", hd[17], 4'h0);
    check("all_held_e18", hd[18], 4'hF);
    check("all_any_e18", ap[18], 1'b1);
    run(0, 30, 4'h0);
    check("all_rel_held_e17", hd[17], 4'hF);
    check("all_rel_held_e18", hd[18], 4'h0);
    check("all_rel_nopulse", npulse(0, 0, 29) + npulse(1, 0, 29) + npulse(2, 0, 29) + npulse(3, 0, 29), 0);
    run(0, 20, 4'h0);

    // Channel 0: short press rejected, then a real press with no repeat.
    run(0, 10, 4'h1);
    run(10, 30, 4'h0);
    check("ch0_short_pulses", npulse(0, 0, 39), 0);
    check("ch0_short_held", nheld(0, 0, 39, 1'b1), 0);
    run(0, 30, 4'h1);
    run(30, 30, 4'h0);
    check("ch0_press_e18", pl[18][0], 1'b1);
    check("ch0_pulse_count", npulse(0, 0, 59), 1);
    check("ch0_rel_held_e47", hd[47][0], 1'b1);
    check("ch0_rel_held_e48", hd[48][0], 1'b0);
    run(0, 20, 4'h0);

    // Channel 1: long hold with auto-repeat.
    run(0, 200, 4'h2);
    run(200, 40, 4'h0);
    check("ch1_press_e18", pl[18][1], 1'b1);
    for (int k = 0; k < 8; k++) check($sformatf("ch1_rep_e%0d", 82 + 16 * k), pl[82 + 16 * k][1], 1'b1);
    check("ch1_pulse_count", npulse(1, 0, 239), 9);
    check("ch1_rel_held_e217", hd[217][1], 1'b1);
    check("ch1_rel_held_e218", hd[218][1], 1'b0);
    run(0, 20, 4'h0);

    // Channel 1: low glitch mid-hold restarts the repeat delay.
    run(0, 40, 4'h2);
    run(40, 5, 4'h0);
    run(45, 105, 4'h2);
    run(150, 50, 4'h0);
    check("glitch_press_e18", pl[18][1], 1'b1);
    check("glitch_no_old_rep", pl[82][1], 1'b0);
    check("glitch_rep_e112", pl[112][1], 1'b1);
    check("glitch_rep_e128", pl[128][1], 1'b1);
    check("glitch_rep_e144", pl[144][1], 1'b1);
    check("glitch_pulse_count", npulse(1, 0, 199), 4);
    check("glitch_held_steady", nheld(1, 18, 167, 1'b0), 0);
    check("glitch_held_e168", hd[168][1], 1'b0);
    run(0, 20, 4'h0);

    // Channels 2 and 3 together.
    run(0, 30, 4'hC);
    run(30, 40, 4'h0);
    check("dual_pulse_e17", pl[17], 4'h0);
    check("dual_pulse_e18", pl[18], 4'hC);
    check("dual_any_e17", ap[17], 1'b0);
    check("dual_any_e18", ap[18], 1'b1);
    check("dual_any_e19", ap[19], 1'b0);
    run(0, 20, 4'h0);

    // Reset in the middle of a press debounce.
    run(0, 10, 4'h1);
    check("mid_rst_pre_pulses", npulse(0, 0, 9), 0);
    reset   = 1'b1;
    rst_err = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      if ((pulse | held) != 4'h0) rst_err++;
      @(negedge clk);
    end
    check("mid_rst_quiet", rst_err, 0);
    reset   = 1'b0;
    prev_pl = 4'h0;
    run(0, 30, 4'h1);
    check("mid_rst_pulse_e17", pl[17][0], 1'b0);
    check("mid_rst_pulse_e18", pl[18][0], 1'b1);
    check("mid_rst_pulse_count", npulse(0, 0, 29), 1);
    run(0, 30, 4'h0);

    check("no_back_to_back", b2b_err, 0);
    check("any_pulse_is_or", or_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
